// File: rtl/note_sequencer.sv
// Beat-quantised note recorder/player that arbitrates the shared 3-bit note bus
// between the live note switches and a small stored sequence.
module note_sequencer #(
    parameter int unsigned BEAT_DIV = 12500000,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AW       = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [2:0]    live_note,
    input  logic          rec_btn,
    input  logic          play_btn,
    input  logic          stop_btn,
    input  logic          loop_en,
    output logic [2:0]    note_out,
    output logic [1:0]    state,
    output logic [AW-1:0] step_idx,
    output logic [AW:0]   seq_len,
    output logic          beat_tick
);

    localparam int unsigned CW = (BEAT_DIV > 1) ? $clog2(BEAT_DIV) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REC  = 2'd1;
    localparam logic [1:0] ST_PLAY = 2'd2;

    localparam logic [CW-1:0] BEAT_LAST = CW'(BEAT_DIV - 1);
    localparam logic [AW:0]   LEN_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] STEP_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] step_q, step_d;
    logic [AW:0]   len_q, len_d;
    logic [2:0]    note_q, note_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic [2:0]    mem_q [DEPTH];
    logic          beat;
    logic          wr_en;
    logic [AW:0]   step_next_ext;

    always_comb begin
        beat          = (state_q != ST_IDLE) && (beat_cnt_q == BEAT_LAST);
        step_next_ext = {1'b0, step_q} + LEN_ONE;
        state_d       = state_q;
        step_d        = step_q;
        len_d         = len_q;
        wr_en         = 1'b0;
        beat_cnt_d    = (state_q == ST_IDLE || beat) ? '0 : beat_cnt_q + CNT_ONE;
        // Live input overrides playback whenever it is non-silent.
        note_d        = (state_q == ST_PLAY && live_note == 3'd0) ? mem_q[step_q] : live_note;

        case (state_q)
            ST_IDLE: begin
                if (rec_btn) begin
                    state_d = ST_REC;
                    step_d  = '0;
                    len_d   = '0;
                end else if (play_btn && len_q != '0) begin
                    state_d = ST_PLAY;
                    step_d  = '0;
                end
            end
            ST_REC: begin
                if (stop_btn) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                end else if (beat && len_q < LEN_FULL) begin
                    wr_en  = 1'b1;
                    len_d  = len_q + LEN_ONE;
                    step_d = step_q + STEP_ONE;
                    if (len_d == LEN_FULL) begin
                        state_d = ST_IDLE;
                        step_d  = '0;
                    end
                end
            end
            ST_PLAY: begin
                if (stop_btn) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                end else if (beat) begin
                    if (step_next_ext == len_q) begin
                        step_d = '0;
                        if (!loop_en) state_d = ST_IDLE;
                    end else begin
                        step_d = step_q + STEP_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase

        if (state_d != state_q) beat_cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            len_q      <= '0;
            note_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            len_q      <= len_d;
            note_q     <= note_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Memory is intentionally not reset; seq_len == 0 marks it invalid.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[step_q] <= live_note;
    end

    assign note_out  = note_q;
    assign state     = state_q;
    assign step_idx  = step_q;
    assign seq_len   = len_q;
    assign beat_tick = beat;

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Records and plays back short melodies of 3-bit note codes (0 = silence, 1..7 = A,B,C,D,E,F,G).
- Sits between the live note-select input and the shared tone generator / seven-segment note decoder.
- Arbitrates which source drives the shared 3-bit note bus: live input or the stored sequence.
- Timing is beat-quantised by an internal clock divider.

Parameters:
- BEAT_DIV, 12500000, clock cycles per beat (4 beats/s at 50 MHz); minimum 2.
- DEPTH, 16, number of note slots in the sequence memory.
- AW, 4, address width; DEPTH == 2**AW.

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- live_note  input  3  note code from the live note switches
- rec_btn  input  1  single-cycle pulse, debounced upstream; start recording
- play_btn  input  1  single-cycle pulse, debounced upstream; start playback
- stop_btn  input  1  single-cycle pulse, debounced upstream; return to IDLE
- loop_en  input  1  1 = playback wraps to slot 0; 0 = playback stops after the last slot
- note_out  output  3  registered note code to the tone generator and seven-seg decoder
- state  output  2  0 = IDLE, 1 = RECORD, 2 = PLAY; 3 is unused
- step_idx  output  AW  current sequence pointer
- seq_len  output  AW+1  number of valid recorded slots, 0..DEPTH
- beat_tick  output  1  one-cycle pulse on the last cycle of each beat

Behaviour:
- Reset (asynchronous, reset_n = 0) forces:
  - state = IDLE, step_idx = 0, seq_len = 0, note_out = 0;
  - beat counter = 0, beat_tick = 0.
  - Memory contents are not cleared; seq_len = 0 invalidates them.
- Beat counter:
  - Counts 0..BEAT_DIV-1 only in RECORD and PLAY; held at 0 in IDLE.
  - Cleared on every state transition.
  - beat_tick = 1 when the counter equals BEAT_DIV-1 and state is RECORD or PLAY.
- Command priority within a cycle: stop_btn > rec_btn > play_btn.
  - Commands not listed for the current state are ignored: rec_btn in PLAY, play_btn in RECORD, stop_btn in IDLE.
- IDLE:
  - rec_btn -> RECORD; clear step_idx and seq_len.
  - play_btn with seq_len != 0 -> PLAY; step_idx = 0.
  - play_btn with seq_len == 0 -> remain in IDLE.
- RECORD:
  - On beat_tick: mem[step_idx] <= live_note; step_idx += 1; seq_len += 1.
  - The write that makes seq_len == DEPTH also transitions to IDLE; step_idx wraps to 0.
  - stop_btn -> IDLE; seq_len is retained.
  - stop_btn coincident with beat_tick: stop wins and no write occurs.
- PLAY:
  - On beat_tick with step_idx < seq_len-1: step_idx += 1.
  - On beat_tick with step_idx == seq_len-1:
    - loop_en = 1: step_idx = 0, remain in PLAY.
    - loop_en = 0: step_idx = 0, go to IDLE.
  - loop_en is sampled at the wrap tick.
  - stop_btn -> IDLE; step_idx = 0.
- note_out, registered with 1-cycle latency from its source:
  - IDLE: live_note.
  - RECORD: live_note (monitoring).
  - PLAY: mem[step_idx], except live_note when live_note != 0. Live input has priority; sequence timing continues underneath.
- Memory:
  - DEPTH x 3 bits, synchronous write, combinational read.
  - Writes occur only in RECORD on beat_tick.
- Counters saturate and never overflow: seq_len never exceeds DEPTH.

Test Plan (BEAT_DIV = 4, DEPTH = 16):
1. Reset and empty play: pulse reset_n low, then play_btn -> state = 0, note_out = 0, seq_len = 0; state stays 0.
2. Record three notes: rec_btn, then live_note = 1, 3, 5, each held across one beat (4 cycles), then stop_btn.
   -> seq_len = 3, state = 0, mem[0..2] = 1, 3, 5.
3. Single-shot playback: loop_en = 0, live_note = 0, play_btn.
   -> note_out = 1, 3, 5, each for 4 cycles starting 1 cycle after entry to PLAY; then state = 0 and note_out = 0.
4. Looped playback with override:
   - loop_en = 1, play_btn -> note_out = 1, 3, 5, 1, 3, …
   - Drive live_note = 7 for 2 cycles mid-beat -> note_out = 7 for those cycles (1-cycle latency); step timing is unchanged.
   - stop_btn -> state = 0, step_idx = 0.
5. Full recording: rec_btn, then 16 beats with live_note = 2.
   -> state = 0 on the 16th beat_tick, seq_len = 16; further cycles produce no writes and no beat_tick.
6. Simultaneous commands:
   - stop_btn + rec_btn in PLAY -> IDLE.
   - rec_btn + play_btn in IDLE -> RECORD.
   - stop_btn on a RECORD beat_tick -> seq_len is unchanged.
   - reset_n low mid-PLAY -> all outputs 0 immediately.
